// File: rtl/char_scroller.sv
// char_scroller: holds a five-character word of 2-bit codes and scrolls it across HEX2..HEX0.
//   clock, reset (async, active-high); load captures data (word[i] = data[2i+1:2i]);
//   enable runs/pauses scrolling; dir 0 advances, 1 retreats;
//   c2/c1/c0 show word[pos], word[pos+1], word[pos+2] (mod 5); pos is the rotation index;
//   tick pulses in the cycle before each step; running is high in RUN.
module char_scroller #(
  parameter int CNT_MAX = 49_999_999,
  parameter int CNT_W   = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] data,
  input  logic       enable,
  input  logic       dir,
  output logic [1:0] c2,
  output logic [1:0] c1,
  output logic [1:0] c0,
  output logic [2:0] pos,
  output logic       tick,
  output logic       running
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t           state;
  logic [9:0]       word;
  logic [CNT_W-1:0] cnt;
  logic             term;
  logic [2:0]       p1, p2, nxt;
  function automatic logic [1:0] ch(input logic [9:0] w, input logic [2:0] i);
    return 2'(w >> {i, 1'b0});
  endfunction
  always_comb begin
    term    = cnt == CNT_W'(CNT_MAX);
    p1      = pos == 3'd4 ? 3'd0 : pos + 3'd1;
    p2      = p1 == 3'd4 ? 3'd0 : p1 + 3'd1;
    nxt     = dir ? (pos == 3'd0 ? 3'd4 : pos - 3'd1) : p1;
    c2      = ch(word, pos);
    c1      = ch(word, p1);
    c0      = ch(word, p2);
    running = state == RUN;
    tick    = running && term && !load;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      word  <= '1;
      pos   <= '0;
      cnt   <= '0;
    end else if (load) begin
      word  <= data;
      pos   <= '0;
      cnt   <= '0;
      state <= enable ? RUN : PAUSE;
    end else if (state == RUN) begin
      // the counting edge completes even when enable has just dropped
      cnt <= term ? '0 : cnt + 1'b1;
      if (term) pos <= nxt;
      if (!enable) state <= PAUSE;
    end else if (state == PAUSE && enable) begin
      state <= RUN;
    end
  end
endmodule
